lcd_status_sequencer: RTL and testbench

//  Parametrised SmartLift LCD text sequencer driving a 16x2 character LCD via LCD_Controller
//  (iDATA/iRS/iStart/oDone handshake). Runs full init + 2-line frame after reset.

---
 rtl/lcd_status_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_lcd_status_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_status_sequencer.sv
// lcd_status_sequencer
//   Writes SmartLift status text to a 16x2 character LCD through an
//   LCD_Controller (iDATA/iRS/iStart/oDone handshake). After reset it sends the
//   full init sequence and both lines. Later it rewrites the text from the DDRAM
//   line-1 address onwards, without a clear, whenever state or floor changes
//   or iREFRESH pulses.
// Ports
//   iCLK, Reset         clock (rising edge), async active-high reset
//   iSTATE, iFLOOR      elevator motion state and current floor
//   iREFRESH            one-cycle request to rewrite the text
//   oLCD_DATA/oLCD_RS   byte and command(0)/char(1) select to the controller
//   oLCD_START          start strobe, held until iLCD_DONE
//   iLCD_DONE           write-complete from the controller
//   oBUSY               high while a frame is in progress
//   oFRAME_DONE         one-cycle pulse when the last entry of a frame completes
module lcd_status_sequencer #(
    parameter int unsigned DLY_CYCLES = 262143,
    parameter int unsigned FLOOR_W    = 4,
    parameter int unsigned MAX_FLOOR  = 9
) (
    input  logic               iCLK,
    input  logic               Reset,
    input  logic [1:0]         iSTATE,
    input  logic [FLOOR_W-1:0] iFLOOR,
    input  logic               iREFRESH,
    output logic [7:0]         oLCD_DATA,
    output logic               oLCD_RS,
    output logic               oLCD_START,
    input  logic               iLCD_DONE,
    output logic               oBUSY,
    output logic               oFRAME_DONE
);
    localparam int unsigned DLY_W       = $clog2(DLY_CYCLES + 1);
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned LAST_IDX    = 37;
    localparam int unsigned REFRESH_IDX = 4;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);

    localparam logic [8*6-1:0]  TXT_PARADO   = "Parado";
    localparam logic [8*9-1:0]  TXT_SUBINDO  = "Subindo +";
    localparam logic [8*10-1:0] TXT_DESCENDO = "Descendo -";
    localparam logic [8*6-1:0]  TXT_ANDAR    = "Andar ";

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DLY, S_NEXT} state_t;

    state_t             state, stateNxt;
    logic [IDX_W-1:0]   idx, idxNxt;
    logic [1:0]         snapSt, snapStNxt;
    logic [FLOOR_W-1:0] snapFl, snapFlNxt;
    logic               initPending, initNxt;
    logic               dirty, dirtyNxt;
    logic [DLY_W-1:0]   dlyCnt, dlyNxt;
    logic [7:0]         dataNxt;
    logic               rsNxt, startNxt, busyNxt, frameDoneNxt;
    logic               changed;
    logic [8:0]         entryVal;

    // Line 1 character at column p, space padded
    function automatic logic [7:0] line1Char(input logic [1:0] st, input int p);
        logic [7:0] c;
        c = 8'h20;
        case (st)
            2'd0:    if (p < 6)  c = TXT_PARADO[8*(5-p) +: 8];
            2'd1:    if (p < 9)  c = TXT_SUBINDO[8*(8-p) +: 8];
            default: if (p < 10) c = TXT_DESCENDO[8*(9-p) +: 8];
        endcase
        return c;
    endfunction

    // Line 2 character at column p: "Andar " + digit + spaces
    function automatic logic [7:0] line2Char(input logic [FLOOR_W-1:0] fl, input int p);
        logic [7:0] c;
        c = 8'h20;
        if (p < 6) begin
            c = TXT_ANDAR[8*(5-p) +: 8];
        end else if (p == 6) begin
            c = (32'(fl) <= MAX_FLOOR) ? (8'h30 + 8'(fl)) : 8'h3F;
        end
        return c;
    endfunction

    // {RS,DATA} for one frame entry, built from the snapshot
    function automatic logic [8:0] tableEntry(input logic [IDX_W-1:0] ix,
                                              input logic [1:0] st,
                                              input logic [FLOOR_W-1:0] fl);
        int i;
        logic [8:0] e;
        i = int'(ix);
        e = 9'h120;
        if      (i == 0)             e = 9'h038;
        else if (i == 1)             e = 9'h00C;
        else if (i == 2)             e = 9'h001;
        else if (i == 3)             e = 9'h006;
        else if (i == 4)             e = 9'h080;
        else if (i <= 20)            e = {1'b1, line1Char(st, i - 5)};
        else if (i == 21)            e = 9'h0C0;
        else if (i <= 37)            e = {1'b1, line2Char(fl, i - 22)};
        return e;
    endfunction

    // State and registered outputs
    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            snapSt      <= '0;
            snapFl      <= '0;
            initPending <= 1'b1;
            dirty       <= 1'b0;
            dlyCnt      <= '0;
            oLCD_DATA   <= '0;
            oLCD_RS     <= 1'b0;
            oLCD_START  <= 1'b0;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            state       <= stateNxt;
            idx         <= idxNxt;
            snapSt      <= snapStNxt;
            snapFl      <= snapFlNxt;
            initPending <= initNxt;
            dirty       <= dirtyNxt;
            dlyCnt      <= dlyNxt;
            oLCD_DATA   <= dataNxt;
            oLCD_RS     <= rsNxt;
            oLCD_START  <= startNxt;
            oBUSY       <= busyNxt;
            oFRAME_DONE <= frameDoneNxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNxt     = state;
        idxNxt       = idx;
        snapStNxt    = snapSt;
        snapFlNxt    = snapFl;
        initNxt      = initPending;
        dirtyNxt     = dirty;
        dlyNxt       = dlyCnt;
        dataNxt      = oLCD_DATA;
        rsNxt        = oLCD_RS;
        startNxt     = oLCD_START;
        busyNxt      = oBUSY;
        frameDoneNxt = 1'b0;
        changed      = (iSTATE != snapSt) || (iFLOOR != snapFl) || iREFRESH;
        entryVal     = tableEntry(idx, snapSt, snapFl);

        // Changes during a frame are deferred to one refresh afterwards
        if (state != S_IDLE && changed) dirtyNxt = 1'b1;

        case (state)
            S_IDLE: begin
                if (initPending || dirty || changed) begin
                    idxNxt    = initPending ? '0 : IDX_W'(REFRESH_IDX);
                    snapStNxt = iSTATE;
                    snapFlNxt = iFLOOR;
                    dirtyNxt  = 1'b0;
                    initNxt   = 1'b0;
                    busyNxt   = 1'b1;
                    stateNxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                {rsNxt, dataNxt} = entryVal;
                startNxt         = 1'b1;
                stateNxt         = S_WAIT;
            end
            S_WAIT: begin
                if (iLCD_DONE) begin
                    startNxt = 1'b0;
                    dlyNxt   = '0;
                    stateNxt = S_DLY;
                end
            end
            S_DLY: begin
                if (dlyCnt == DLY_LAST) begin
                    dlyNxt   = '0;
                    stateNxt = S_NEXT;
                end else begin
                    dlyNxt = dlyCnt + DLY_W'(1);
                end
            end
            S_NEXT: begin
                if (idx == IDX_W'(LAST_IDX)) begin
                    frameDoneNxt = 1'b1;
                    busyNxt      = 1'b0;
                    stateNxt     = S_IDLE;
                end else begin
                    idxNxt   = idx + IDX_W'(1);
                    stateNxt = S_LOAD;
                end
            end
            default: stateNxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lcd_status_sequencer.sv
// tb_lcd_status_sequencer
//   Directed bench for lcd_status_sequencer with a stub LCD controller whose
//   done latency is adjustable. Writes are captured at each rising start strobe.
module tb_lcd_status_sequencer;
    localparam int unsigned DLY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] iSTATE = 2'd0;
    logic [3:0] iFLOOR = 4'd3;
    logic       iREFRESH = 1'b0;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS, oLCD_START, oBUSY, oFRAME_DONE;
    logic       lcdDone;

    int checks = 0;
    int errors = 0;

    int doneLat = 0;
    int stubCnt;

    logic [8:0] wrQ[$];
    int         hiQ[$];
    logic [8:0] heldWord;
    int         highCnt = 0;
    int         stabErr = 0;
    int         lateDrop = 0;
    logic       prevStart = 1'b0;
    logic       doneSeen = 1'b0;

    always #5 clk = ~clk;

    lcd_status_sequencer #(.DLY_CYCLES(DLY), .FLOOR_W(4), .MAX_FLOOR(9)) dut (
        .iCLK(clk), .Reset(rst), .iSTATE(iSTATE), .iFLOOR(iFLOOR), .iREFRESH(iREFRESH),
        .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_START(oLCD_START),
        .iLCD_DONE(lcdDone), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
    );

    // Stub controller: done pulses doneLat+1 clocks after start is seen
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stubCnt <= 0;
            lcdDone <= 1'b0;
        end else begin
            lcdDone <= 1'b0;
            if (oLCD_START && !lcdDone) begin
                if (stubCnt == doneLat) begin
                    lcdDone <= 1'b1;
                    stubCnt <= 0;
                end else begin
                    stubCnt <= stubCnt + 1;
                end
            end else begin
                stubCnt <= 0;
            end
        end
    end

    // Write capture and handshake observation
    always @(negedge clk) begin
        if (oLCD_START && !prevStart) begin
            wrQ.push_back({oLCD_RS, oLCD_DATA});
            heldWord = {oLCD_RS, oLCD_DATA};
            highCnt  = 1;
        end else if (oLCD_START) begin
            highCnt++;
            if ({oLCD_RS, oLCD_DATA} !== heldWord) stabErr++;
        end else if (prevStart) begin
            hiQ.push_back(highCnt);
        end
        if (doneSeen && oLCD_START) lateDrop++;
        doneSeen  = lcdDone;
        prevStart = oLCD_START;
    end

    function automatic logic [8:0] expEntry(input int idx, input int st, input int fl);
        string l1;
        string l2;
        int    p;
        case (idx)
            0:  return 9'h038;
            1:  return 9'h00C;
            2:  return 9'h001;
            3:  return 9'h006;
            4:  return 9'h080;
            21: return 9'h0C0;
            default: ;
        endcase
        if (st == 0)      l1 = "Parado";
        else if (st == 1) l1 = "Subindo +";
        else              l1 = "Descendo -";
        l2 = "Andar ";
        if (idx >= 5 && idx <= 20) begin
            p = idx - 5;
            if (p < l1.len()) return {1'b1, l1[p]};
            return 9'h120;
        end
        p = idx - 22;
        if (p < 6)  return {1'b1, l2[p]};
        if (p == 6) return (fl <= 9) ? (9'h130 + 9'(fl)) : 9'h13F;
        return 9'h120;
    endfunction

    task automatic waitFrame(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (oFRAME_DONE === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitWrites(input int n);
        for (int i = 0; i < 2000 && wrQ.size() < n; i++) @(negedge clk);
    endtask

    task automatic pulseRefresh();
        @(negedge clk);
        iREFRESH = 1'b1;
        @(negedge clk);
        iREFRESH = 1'b0;
    endtask

    task automatic test_reset();
        wrQ.delete();
        hiQ.delete();
        #1;
        checks++;
        if ({oLCD_DATA, oLCD_RS, oLCD_START, oBUSY, oFRAME_DONE} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", {oLCD_DATA, oLCD_RS, oLCD_START, oBUSY, oFRAME_DONE});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (oBUSY !== 1'b1 || oLCD_START !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge busy=%b start=%b want busy=1 start=0", oBUSY, oLCD_START);
        end
        @(posedge clk); #1;
        checks++;
        if (oLCD_START !== 1'b1 || {oLCD_RS, oLCD_DATA} !== 9'h038) begin
            errors++;
            $display("FAIL reset_first_write start=%b word=%h want 1/038", oLCD_START, {oLCD_RS, oLCD_DATA});
        end
    endtask

    task automatic test_full_frame();
        bit got;
        waitFrame(2000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL full_frame_timeout got 0 want 1"); end
        checks++;
        if (oBUSY !== 1'b0) begin errors++; $display("FAIL full_frame_busy got %b want 0", oBUSY); end
        checks++;
        if (wrQ.size() != 38) begin errors++; $display("FAIL full_frame_count got %0d want 38", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 38; i++) begin
            checks++;
            if (wrQ[i] !== expEntry(i, 0, 3)) begin
                errors++;
                $display("FAIL full_frame_entry[%0d] got %h want %h", i, wrQ[i], expEntry(i, 0, 3));
            end
        end
        for (int i = 0; i < hiQ.size(); i++) begin
            checks++;
            if (hiQ[i] != 2) begin errors++; $display("FAIL full_frame_start_len[%0d] got %0d want 2", i, hiQ[i]); end
        end
        @(negedge clk);
        checks++;
        if (oFRAME_DONE !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", oFRAME_DONE); end
    endtask

    task automatic test_refresh_latency();
        bit got;
        wrQ.delete();
        hiQ.delete();
        @(negedge clk);
        iSTATE = 2'd1;
        @(posedge clk); #1;
        checks++;
        if (oLCD_START !== 1'b0) begin errors++; $display("FAIL latency_edge1 start got %b want 0", oLCD_START); end
        @(posedge clk); #1;
        checks++;
        if (oLCD_START !== 1'b1 || {oLCD_RS, oLCD_DATA} !== 9'h080) begin
            errors++;
            $display("FAIL latency_edge2 start=%b word=%h want 1/080", oLCD_START, {oLCD_RS, oLCD_DATA});
        end
        waitFrame(2000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL refresh_timeout got 0 want 1"); end
        checks++;
        if (wrQ.size() != 34) begin errors++; $display("FAIL refresh_count got %0d want 34", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 34; i++) begin
            checks++;
            if (wrQ[i] !== expEntry(i + 4, 1, 3)) begin
                errors++;
                $display("FAIL refresh_entry[%0d] got %h want %h", i, wrQ[i], expEntry(i + 4, 1, 3));
            end
        end
    endtask

    task automatic test_mid_frame_change();
        bit got;
        bit busySeen;
        wrQ.delete();
        @(negedge clk);
        iSTATE = 2'd0;
        waitWrites(10);
        iFLOOR = 4'd4;
        pulseRefresh();
        waitFrame(2000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL mid_first_timeout got 0 want 1"); end
        checks++;
        if (wrQ.size() != 34) begin errors++; $display("FAIL mid_first_count got %0d want 34", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 34; i++) begin
            checks++;
            if (wrQ[i] !== expEntry(i + 4, 0, 3)) begin
                errors++;
                $display("FAIL mid_first_entry[%0d] got %h want %h", i, wrQ[i], expEntry(i + 4, 0, 3));
            end
        end
        wrQ.delete();
        waitFrame(2000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL mid_refresh_timeout got 0 want 1"); end
        checks++;
        if (wrQ.size() != 34) begin errors++; $display("FAIL mid_refresh_count got %0d want 34", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 34; i++) begin
            checks++;
            if (wrQ[i] !== expEntry(i + 4, 0, 4)) begin
                errors++;
                $display("FAIL mid_refresh_entry[%0d] got %h want %h", i, wrQ[i], expEntry(i + 4, 0, 4));
            end
        end
        busySeen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (oBUSY) busySeen = 1'b1;
        end
        checks++;
        if (busySeen) begin errors++; $display("FAIL mid_single_refresh busy seen=1 want 0"); end
    endtask

    task automatic test_floor_digits();
        bit got;
        int sts[3] = '{2, 3, 3};
        int fls[3] = '{12, 9, 10};
        for (int k = 0; k < 3; k++) begin
            wrQ.delete();
            @(negedge clk);
            iSTATE = 2'(sts[k]);
            iFLOOR = 4'(fls[k]);
            waitFrame(2000, got);
            checks++;
            if (!got) begin errors++; $display("FAIL digit_timeout case %0d got 0 want 1", k); end
            checks++;
            if (wrQ.size() != 34) begin errors++; $display("FAIL digit_count case %0d got %0d want 34", k, wrQ.size()); end
            for (int i = 0; i < wrQ.size() && i < 34; i++) begin
                checks++;
                if (wrQ[i] !== expEntry(i + 4, sts[k], fls[k])) begin
                    errors++;
                    $display("FAIL digit_entry case %0d [%0d] got %h want %h", k, i, wrQ[i], expEntry(i + 4, sts[k], fls[k]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit got;
        wrQ.delete();
        pulseRefresh();
        waitWrites(20);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({oLCD_DATA, oLCD_RS, oLCD_START, oBUSY, oFRAME_DONE} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 000", {oLCD_DATA, oLCD_RS, oLCD_START, oBUSY, oFRAME_DONE});
        end
        @(negedge clk);
        @(negedge clk);
        wrQ.delete();
        hiQ.delete();
        rst = 1'b0;
        waitFrame(2000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL reset_mid_timeout got 0 want 1"); end
        checks++;
        if (wrQ.size() != 38) begin errors++; $display("FAIL reset_mid_count got %0d want 38", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 38; i++) begin
            checks++;
            if (wrQ[i] !== expEntry(i, 3, 10)) begin
                errors++;
                $display("FAIL reset_mid_entry[%0d] got %h want %h", i, wrQ[i], expEntry(i, 3, 10));
            end
        end
    endtask

    task automatic test_slow_done();
        bit got;
        doneLat = 10;
        wrQ.delete();
        hiQ.delete();
        pulseRefresh();
        waitFrame(3000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL slow_timeout got 0 want 1"); end
        checks++;
        if (hiQ.size() != 34) begin errors++; $display("FAIL slow_count got %0d want 34", hiQ.size()); end
        for (int i = 0; i < hiQ.size(); i++) begin
            checks++;
            if (hiQ[i] != 12) begin errors++; $display("FAIL slow_start_len[%0d] got %0d want 12", i, hiQ[i]); end
        end
        for (int i = 0; i < wrQ.size() && i < 34; i++) begin
            checks++;
            if (wrQ[i] !== expEntry(i + 4, 3, 10)) begin
                errors++;
                $display("FAIL slow_entry[%0d] got %h want %h", i, wrQ[i], expEntry(i + 4, 3, 10));
            end
        end
        doneLat = 0;
    endtask

    task automatic test_handshake_integrity();
        checks++;
        if (stabErr != 0) begin errors++; $display("FAIL data_stable changes got %0d want 0", stabErr); end
        checks++;
        if (lateDrop != 0) begin errors++; $display("FAIL start_drop late got %0d want 0", lateDrop); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_refresh_latency();
        test_mid_frame_change();
        test_floor_digits();
        test_reset_mid_frame();
        test_slow_done();
        test_handshake_integrity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
